// File: rtl/prog_loader.sv
// Instruction memory for the single-cycle core: loads a length-prefixed, XOR-checked
// byte stream into program memory and holds the core in reset until the load is clean.
module prog_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  input  logic [31:0] inst_adr,
  output logic [31:0] inst,
  output logic        cpu_rst,
  output logic        loaded,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t              r_state;
  logic                r_rx_ready;
  logic                r_cpu_rst;
  logic                r_loaded;
  logic                r_error;
  logic [15:0]         r_word_count;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_cnt;
  logic [ADDR_W-1:0]   r_widx;
  logic [7:0]          r_chk;
  logic [23:0]         r_asm;
  logic [31:0]         r_mem [DEPTH];

  state_t              w_next;
  logic                w_fire;
  logic [15:0]         w_len;
  logic [31:0]         w_word;
  logic                w_word_done;
  logic                w_last_word;
  logic                w_wr_en;
  logic                w_adr_in_range;
  logic                w_unused_adr_bits;

  assign w_fire      = rx_valid && r_rx_ready;
  assign w_len       = {r_len[15:8], rx_byte};
  assign w_word      = {r_asm, rx_byte};
  assign w_word_done = (r_state == S_DATA) && w_fire && (r_byte_cnt == 2'd3);
  assign w_last_word = ({{(16-ADDR_W){1'b0}}, r_widx} == (r_len - 16'd1));
  assign w_wr_en     = w_word_done;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERR: if (load_req) w_next = S_LEN_HI;
      S_LEN_HI:             if (w_fire) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_fire) begin
          if (32'(w_len) > DEPTH)  w_next = S_ERR;
          else if (w_len == 16'd0) w_next = S_CHK;
          else                     w_next = S_DATA;
        end
      end
      S_DATA:  if (w_word_done && w_last_word) w_next = S_CHK;
      S_CHK:   if (w_fire) w_next = (rx_byte == r_chk) ? S_RUN : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_loaded     <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
      r_byte_cnt   <= '0;
      r_widx       <= '0;
      r_chk        <= '0;
      r_asm        <= '0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK});
      r_loaded   <= (w_next == S_RUN);
      r_error    <= (w_next == S_ERR);
      // Core leaves reset one cycle after RUN is entered, and re-enters it on the
      // same edge that accepts a reload request.
      r_cpu_rst  <= !((r_state == S_RUN) && (w_next == S_RUN));

      case (r_state)
        S_LEN_HI: if (w_fire) r_len[15:8] <= rx_byte;
        S_LEN_LO: begin
          if (w_fire) begin
            r_len        <= w_len;
            r_word_count <= w_len;
            r_widx       <= '0;
            r_chk        <= '0;
            r_byte_cnt   <= '0;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_chk      <= r_chk ^ rx_byte;
            r_asm      <= {r_asm[15:0], rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_widx <= r_widx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: program memory has no reset; a mid-load reset must leave already
  // written words intact, and clearing a RAM array would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_widx] <= w_word;
  end

  assign w_adr_in_range    = (inst_adr[31:ADDR_W+2] == '0);
  assign w_unused_adr_bits = ^inst_adr[1:0];
  assign inst              = w_adr_in_range ? r_mem[inst_adr[ADDR_W+1:2]] : 32'h0;

  assign rx_ready   = r_rx_ready;
  assign cpu_rst    = r_cpu_rst;
  assign loaded     = r_loaded;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready;
  logic [31:0] inst_adr = 32'h0;
  logic [31:0] inst;
  logic        cpu_rst;
  logic        loaded;
  logic        error;
  logic [15:0] word_count;

  prog_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .inst_adr   (inst_adr),
    .inst       (inst),
    .cpu_rst    (cpu_rst),
    .loaded     (loaded),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef enum int {K_INST, K_RDY, K_LOADED, K_ERROR, K_CPURST, K_WC, K_ACC, K_CYC} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   acc_base = 0;
  int   cyc = 0;
  int   cyc_base = 0;
  int   stall_total = 0;

  // Independent observers of accepted bytes and elapsed cycles.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rx_valid && rx_ready) acc_cnt = acc_cnt + 1;
  end

  // Monitor: compare every queued expectation at the falling edge.
  initial forever begin
    exp_t        e;
    logic [31:0] act;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_INST:   act = inst;
        K_RDY:    act = {31'b0, rx_ready};
        K_LOADED: act = {31'b0, loaded};
        K_ERROR:  act = {31'b0, error};
        K_CPURST: act = {31'b0, cpu_rst};
        K_WC:     act = {16'b0, word_count};
        K_ACC:    act = 32'(acc_cnt - acc_base);
        default:  act = 32'(cyc - cyc_base);
      endcase
      total = total + 1;
      if (act !== e.val) begin
        bad = bad + 1;
        $display("FAIL %s: got %h expected %h", e.tag, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic ld, input logic er,
                              input logic cr, input logic rd);
    check({tag, "_loaded"},  K_LOADED, {31'b0, ld});
    check({tag, "_error"},   K_ERROR,  {31'b0, er});
    check({tag, "_cpu_rst"}, K_CPURST, {31'b0, cr});
    check({tag, "_rx_ready"}, K_RDY,   {31'b0, rd});
  endtask

  task automatic check_inst(input string tag, input logic [31:0] adr, input logic [31:0] v);
    inst_adr = adr;
    check(tag, K_INST, v);
    tick();
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Present one byte, optionally after idle cycles, and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int stall);
    bit done;
    done = 1'b0;
    if (stall > 0) begin
      rx_valid = 1'b0;
      repeat (stall) begin
        tick();
        stall_total = stall_total + 1;
      end
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rx_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL send_timeout: byte %h not accepted, want accept within 20 cycles", b);
    end
  endtask

  task automatic send_stream(input byte_q_t s, input int stall_max);
    foreach (s[i]) send_byte(s[i], (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0);
    rx_valid = 1'b0;
  endtask

  byte_q_t basic_ok  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
  byte_q_t basic_bad = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h88};
  byte_q_t one_word  = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  byte_q_t partial   = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

  initial begin
    // Reset state
    repeat (3) tick();
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_wc", K_WC, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Basic load
    pulse_load();
    check_status("basic_lenhi", 1'b0, 1'b0, 1'b1, 1'b1);
    send_stream(basic_ok, 0);
    check_status("basic_chk_edge", 1'b1, 1'b0, 1'b1, 1'b0);
    check("basic_wc", K_WC, 32'd2);
    tick();
    check("basic_cpu_rst_release", K_CPURST, 32'h0);
    check_inst("basic_inst0", 32'h0, 32'h20080005);
    check_inst("basic_inst4", 32'h4, 32'hAC080000);
    check_inst("basic_inst6", 32'h6, 32'hAC080000);

    // Bad checksum, then recovery with a different one-word image
    pulse_load();
    check_status("reload_from_run", 1'b0, 1'b0, 1'b1, 1'b1);
    send_stream(basic_bad, 0);
    check_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("badchk_cpu_rst_held", K_CPURST, 32'h1);
    pulse_load();
    send_stream(one_word, 0);
    check_status("recover", 1'b1, 1'b0, 1'b1, 1'b0);
    check("recover_wc", K_WC, 32'd1);
    tick();
    check("recover_cpu_rst", K_CPURST, 32'h0);
    check_inst("recover_inst0", 32'h0, 32'h12345678);
    check_inst("recover_inst4", 32'h4, 32'hAC080000);

    // Oversize length, then empty image
    pulse_load();
    send_stream('{8'h01, 8'h01}, 0);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
    check("oversize_wc", K_WC, 32'h0101);
    tick();
    pulse_load();
    send_stream('{8'h00, 8'h00}, 0);
    check_status("empty_in_chk", 1'b0, 1'b0, 1'b1, 1'b1);
    check("empty_wc", K_WC, 32'h0);
    send_stream('{8'h00}, 0);
    check_status("empty_done", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Handshake stalls: byte held while not ready must not be consumed
    acc_base = acc_cnt;
    rx_valid = 1'b1;
    rx_byte  = 8'h00;
    repeat (3) tick();
    check("stall_no_consume_in_run", K_ACC, 32'h0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    cyc_base    = cyc;
    stall_total = 0;
    send_stream(basic_ok, 2);
    check("stall_accepted_bytes", K_ACC, 32'd11);
    check("stall_cycles", K_CYC, 32'(11 + stall_total));
    check_status("stall_done", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_inst("stall_inst0", 32'h0, 32'h20080005);
    check_inst("stall_inst4", 32'h4, 32'hAC080000);

    // Mid-load reset after 6 payload bytes
    pulse_load();
    send_stream(partial, 0);
    rst = 1'b1;
    tick();
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_wc", K_WC, 32'h0);
    rst = 1'b0;
    tick();
    check_inst("midrst_inst0", 32'h0, 32'h12345678);
    check_inst("midrst_inst4", 32'h4, 32'hAC080000);
    pulse_load();
    send_stream(basic_ok, 0);
    check_status("after_midrst", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_inst("after_midrst_inst0", 32'h0, 32'h20080005);

    // Address bounds and reload from RUN
    check("run_cpu_rst", K_CPURST, 32'h0);
    check_inst("oob_0x400", 32'h00000400, 32'h0);
    check_inst("oob_high", 32'h80000000, 32'h0);
    pulse_load();
    check_status("reload", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
